// File: rtl/vector_store_unit.sv
// vector_store_unit
// Writes an eight-lane, 32-bit-per-lane vector to memory one lane per cycle.
// Lane i goes to base + i*STRIDE; a lane whose mask bit is 0 still takes one
// cycle but does not assert mem_we.
//
// Optional feature: define VSTORE_CLAMP_EN to saturate each lane, read as a
// signed value, to 0..255 before it is written.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   source offers a vector
//   in_ready   unit is idle and accepts a vector this cycle
//   in_data    eight lanes, lane i = bits [32i+31:32i]
//   in_mask    bit i enables the write of lane i
//   in_base    byte address of lane 0
//   mem_we     memory write strobe
//   mem_addr   write address
//   mem_wdata  write data
//   mem_stall  memory cannot finish the current write
//   done       one-cycle pulse after the last lane
//
// state  | meaning
// IDLE   | waiting for a vector, in_ready=1
// WRITE  | presenting lane idx to memory
// DONE   | single-cycle done pulse, then back to IDLE
module vector_store_unit #(
  parameter int ADDR_W = 32,
  parameter int STRIDE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [255:0]      in_data,
  input  logic [7:0]        in_mask,
  input  logic [ADDR_W-1:0] in_base,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_stall,
  output logic              done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [255:0]      data_q, data_d;
  logic [7:0]        mask_q, mask_d;
  logic [ADDR_W-1:0] base_q, base_d;

  logic              in_write;
  logic              lane_en;
  logic [31:0]       lane_val;
  logic [31:0]       lane_out;

  assign in_write = (state_q == ST_WRITE);
  assign lane_en  = mask_q[idx_q];
  assign lane_val = data_q[{idx_q, 5'b00000} +: 32];

`ifdef VSTORE_CLAMP_EN
  // Signed saturation to an unsigned byte: sign bit set means negative.
  always_comb begin
    lane_out = lane_val;
    if (lane_val[31]) begin
      lane_out = 32'd0;
    end else if (|lane_val[30:8]) begin
      lane_out = 32'd255;
    end
  end
`else
  assign lane_out = lane_val;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    data_d  = data_q;
    mask_d  = mask_q;
    base_d  = base_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mask_d  = in_mask;
          base_d  = in_base;
          idx_d   = 3'd0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // A stall only matters when a write is actually being issued; a
        // masked-off lane always retires in one cycle.
        if (!(mem_stall && lane_en)) begin
          if (idx_q == 3'd7) begin
            state_d = ST_DONE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      ST_DONE: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
      default: begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      data_q  <= '0;
      mask_q  <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      base_q  <= base_d;
    end
  end

  // Outputs are pure functions of registered state, so holding idx during a
  // stall automatically holds address, data and strobe.
  assign in_ready  = (state_q == ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign mem_we    = in_write && lane_en;
  assign mem_addr  = in_write ? (base_q + ADDR_W'(idx_q) * ADDR_W'(STRIDE)) : '0;
  assign mem_wdata = in_write ? lane_out : 32'd0;

endmodule

// File: tb/tb_vector_store_unit.sv
module tb_vector_store_unit;

  localparam int ADDR_W = 32;
  localparam int STRIDE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [255:0]      in_data;
  logic [7:0]        in_mask;
  logic [ADDR_W-1:0] in_base;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_stall;
  logic              done;

  int checks   = 0;
  int failures = 0;

  vector_store_unit #(.ADDR_W(ADDR_W), .STRIDE(STRIDE)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_base   (in_base),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_stall (mem_stall),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference for what memory should receive for a given lane value.
  function automatic logic [31:0] exp_wdata(input logic [31:0] lane);
`ifdef VSTORE_CLAMP_EN
    int v;
    v = $signed(lane);
    if (v < 0) return 32'd0;
    if (v > 255) return 32'd255;
    return lane;
`else
    return lane;
`endif
  endfunction

  // Drives one vector and checks the whole expected cycle trace: one cycle per
  // lane, plus the stall count for enabled lanes, then one done cycle, then idle.
  // stalls holds 3 bits per lane (number of stall cycles applied to that lane).
  task automatic run_vector(input logic [255:0] d, input logic [7:0] m,
                            input logic [31:0] b, input logic [23:0] stalls,
                            input string name);
    int n;
    logic [31:0] ea, ed;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before got=%b exp=1", name, in_ready);
    end
    in_valid  = 1'b1;
    in_data   = d;
    in_mask   = m;
    in_base   = b;
    mem_stall = 1'($urandom_range(0, 1));
    step;
    in_valid = 1'b0;
    in_data  = {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    in_mask  = 8'($urandom());
    in_base  = $urandom();
    for (int lane = 0; lane < 8; lane++) begin
      n  = m[lane] ? 1 + int'(stalls[3*lane +: 3]) : 1;
      ea = b + 32'(lane * STRIDE);
      ed = exp_wdata(d[32*lane +: 32]);
      for (int c = 0; c < n; c++) begin
        mem_stall = m[lane] ? (c < n - 1) : 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        checks++;
        if (mem_we !== m[lane]) begin
          failures++;
          $display("FAIL %s we lane%0d cyc%0d got=%b exp=%b", name, lane, c, mem_we, m[lane]);
        end
        checks++;
        if (mem_addr !== ea || mem_wdata !== ed) begin
          failures++;
          $display("FAIL %s addr/data lane%0d cyc%0d got=%h/%h exp=%h/%h",
                   name, lane, c, mem_addr, mem_wdata, ea, ed);
        end
        checks++;
        if (in_ready !== 1'b0 || done !== 1'b0) begin
          failures++;
          $display("FAIL %s ready/done lane%0d got=%b/%b exp=0/0", name, lane, in_ready, done);
        end
        step;
      end
    end
    mem_stall = 1'b1;
    in_valid  = 1'b0;
    checks++;
    if (done !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wdata !== 32'd0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s done_cycle got done=%b we=%b addr=%h wd=%h rdy=%b exp 1 0 0 0 0",
               name, done, mem_we, mem_addr, mem_wdata, in_ready);
    end
    step;
    mem_stall = 1'b0;
    checks++;
    if (done !== 1'b0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL %s after_done got done=%b rdy=%b we=%b exp 0 1 0",
               name, done, in_ready, mem_we);
    end
  endtask

  function automatic logic [255:0] seq_lanes(input int first);
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'(first + i);
    return d;
  endfunction

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; mem_stall = 1'b1;
    in_data = '1; in_mask = 8'hFF; in_base = 32'h55;
    step;
    step;
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'd0 ||
        mem_wdata !== 32'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got rdy=%b we=%b addr=%h wd=%h done=%b exp 1 0 0 0 0",
               in_ready, mem_we, mem_addr, mem_wdata, done);
    end
    rst = 1'b0; in_valid = 1'b0; mem_stall = 1'b0;
    step;
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL idle_hold got rdy=%b we=%b exp 1 0", in_ready, mem_we);
    end
  endtask

  task automatic test_directed;
    logic [255:0] d;
    int v[8];
    run_vector(seq_lanes(100), 8'hFF, 32'h100, 24'd0, "basic");
    run_vector(seq_lanes(100), 8'hFF, 32'h100, 24'(3 << 6), "stall_lane2");
    run_vector(seq_lanes(100), 8'hA5, 32'h100, 24'd0, "mask_a5");
    run_vector(seq_lanes(100), 8'h5A, 32'h100, 24'o7070_7070, "mask_5a_stall");
    run_vector('0, 8'hFF, 32'h40, 24'd0, "zero_lanes");
    run_vector(seq_lanes(7), 8'h00, 32'h200, 24'o7777_7777, "zero_mask");
    run_vector(seq_lanes(1), 8'hFF, 32'hFFFF_FFF8, 24'd0, "addr_wrap");
    v = '{-3, -2, -1, 0, 1, 10300, 255, 256};
    for (int i = 0; i < 8; i++) d[32*i +: 32] = 32'(v[i]);
    run_vector(d, 8'hFF, 32'h300, 24'd0, "clamp_vals");
  endtask

  task automatic test_random;
    logic [255:0] d;
    logic [23:0]  s;
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 3))
          0: d[32*i +: 32] = 32'($urandom_range(0, 300));
          1: d[32*i +: 32] = -32'($urandom_range(1, 300));
          default: d[32*i +: 32] = $urandom();
        endcase
        s[3*i +: 3] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 3)) : 3'd0;
      end
      run_vector(d, 8'($urandom()), $urandom(), s, "random");
    end
  endtask

  task automatic test_reset_abort;
    logic [31:0] b;
    b = 32'h1000;
    in_valid = 1'b1; in_data = seq_lanes(100); in_mask = 8'hFF; in_base = b;
    mem_stall = 1'b0;
    step;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step;
    checks++;
    if (mem_addr !== b + 32'd16 || mem_we !== 1'b1) begin
      failures++;
      $display("FAIL abort_at_lane4 got addr=%h we=%b exp=%h 1", mem_addr, mem_we, b + 32'd16);
    end
    rst = 1'b1;
    step;
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0 || done !== 1'b0 || mem_addr !== 32'd0) begin
      failures++;
      $display("FAIL abort_reset got rdy=%b we=%b done=%b addr=%h exp 1 0 0 0",
               in_ready, mem_we, done, mem_addr);
    end
    for (int i = 0; i < 10; i++) begin
      step;
      checks++;
      if (mem_we !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL abort_quiet cyc%0d got we=%b done=%b exp 0 0", i, mem_we, done);
      end
    end
  endtask

  task automatic test_reset_priority;
    in_valid = 1'b1; in_data = seq_lanes(5); in_mask = 8'hFF; in_base = 32'h80;
    rst = 1'b1;
    step;
    rst = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority got rdy=%b we=%b exp 1 0", in_ready, mem_we);
    end
    step;
    checks++;
    if (in_ready !== 1'b1 || mem_we !== 1'b0) begin
      failures++;
      $display("FAIL rst_priority_next got rdy=%b we=%b exp 1 0", in_ready, mem_we);
    end
    run_vector(seq_lanes(200), 8'hFF, 32'h80, 24'd0, "post_reset");
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_reset_abort;
    test_reset_priority;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
